axis_packet_source: RTL and testbench

Parametrised AXI4-Stream payload generator that feeds packet_gen in the Ethernet TX path. It replaces ad-hoc timer/counter logic in top-level designs. The block emits packets of runtime-configurable length, separated by a configurable idle gap. Data is drawn from one of four pattern modes. It is fully AXIS-compliant under backpressure and counts completed packets.

---
 rtl/axis_packet_source.sv | 182 ++++++++++++++++++
 tb/tb_axis_packet_source.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_packet_source.sv
// AXI4-Stream payload generator: configurable-length packets separated by an
// idle gap, four data modes, full backpressure support and a packet counter.
module axis_packet_source #(
  parameter int WORD_BYTES  = 4,
  parameter int MAX_WORDS   = 1024,
  parameter int GAP_W       = 32,
  parameter int SWAP_ENDIAN = 0,
  localparam int W  = WORD_BYTES * 8,
  localparam int LW = $clog2(MAX_WORDS + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [LW-1:0]    cfg_len,
  input  logic [GAP_W-1:0] cfg_gap,
  input  logic [1:0]       cfg_mode,
  input  logic [W-1:0]     cfg_pattern,
  output logic [W-1:0]     m_axis_tdata,
  output logic             m_axis_tvalid,
  input  logic             m_axis_tready,
  output logic             m_axis_tlast,
  output logic [31:0]      pkt_count,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    MODE_COUNT = 2'd0,
    MODE_INDEX = 2'd1,
    MODE_PRBS  = 2'd2,
    MODE_CONST = 2'd3
  } mode_t;

  state_t           state;
  mode_t            mode_q;
  logic [LW-1:0]    len_q;
  logic [LW-1:0]    word_idx;
  logic [GAP_W-1:0] gap_q;
  logic [GAP_W-1:0] gap_cnt;
  logic [W-1:0]     pattern_q;
  logic [W-1:0]     run_cnt;
  logic [31:0]      lfsr;
  logic [31:0]      pkt_cnt_q;
  logic             tvalid_q;
  logic             tlast_q;
  logic             busy_q;

  logic             hs;
  logic             start_pkt;
  logic [LW-1:0]    eff_len;
  logic [31:0]      lfsr_next;
  logic [W-1:0]     lfsr_word;
  logic [W-1:0]     data_sel;
  logic [W-1:0]     data_out;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    hs        = tvalid_q && m_axis_tready;
    lfsr_next = {lfsr[30:0], lfsr[31] ^ lfsr[21] ^ lfsr[1] ^ lfsr[0]};

    if (cfg_len == '0) begin
      eff_len = LW'(1);
    end else if (cfg_len > LW'(MAX_WORDS)) begin
      eff_len = LW'(MAX_WORDS);
    end else begin
      eff_len = cfg_len;
    end

    // A new packet starts from IDLE, back-to-back after tlast, or at the end of the gap.
    start_pkt = 1'b0;
    case (state)
      IDLE:    start_pkt = enable;
      SEND:    start_pkt = hs && tlast_q && (gap_q == '0) && enable;
      GAP:     start_pkt = (gap_cnt == GAP_W'(1)) && enable;
      default: start_pkt = 1'b0;
    endcase
  end

  always_comb begin
    lfsr_word = '0;
    for (int i = 0; i < W; i++) begin
      lfsr_word[i] = lfsr[i % 32];
    end
  end

  always_comb begin
    case (mode_q)
      MODE_COUNT: data_sel = run_cnt;
      MODE_INDEX: data_sel = W'(word_idx);
      MODE_PRBS:  data_sel = lfsr_word;
      default:    data_sel = pattern_q;
    endcase

    data_out = data_sel;
    if (SWAP_ENDIAN != 0) begin
      for (int b = 0; b < WORD_BYTES; b++) begin
        data_out[8*b +: 8] = data_sel[8*(WORD_BYTES-1-b) +: 8];
      end
    end
  end

  // Generator registers only move on a handshake or packet start, so the word holds while stalled.
  assign m_axis_tdata  = tvalid_q ? data_out : '0;
  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tlast  = tlast_q;
  assign pkt_count     = pkt_cnt_q;
  assign busy          = busy_q;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      mode_q    <= MODE_COUNT;
      len_q     <= LW'(1);
      word_idx  <= '0;
      gap_q     <= '0;
      gap_cnt   <= '0;
      pattern_q <= '0;
      run_cnt   <= '0;
      lfsr      <= 32'hFFFF_FFFF;
      pkt_cnt_q <= '0;
      tvalid_q  <= 1'b0;
      tlast_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      // Each generator advances only when one of its own words is consumed.
      if (hs) begin
        if (mode_q == MODE_COUNT) run_cnt <= run_cnt + W'(1);
        if (mode_q == MODE_PRBS)  lfsr    <= lfsr_next;
        if (tlast_q)              pkt_cnt_q <= pkt_cnt_q + 32'd1;
      end

      if (start_pkt) begin
        state     <= SEND;
        busy_q    <= 1'b1;
        tvalid_q  <= 1'b1;
        tlast_q   <= (eff_len == LW'(1));
        word_idx  <= '0;
        len_q     <= eff_len;
        gap_q     <= cfg_gap;
        mode_q    <= mode_t'(cfg_mode);
        pattern_q <= cfg_pattern;
      end else begin
        case (state)
          SEND: begin
            if (hs) begin
              if (tlast_q) begin
                word_idx <= '0;
                tvalid_q <= 1'b0;
                tlast_q  <= 1'b0;
                if (gap_q != '0) begin
                  state   <= GAP;
                  gap_cnt <= gap_q;
                end else begin
                  state  <= IDLE;
                  busy_q <= 1'b0;
                end
              end else begin
                word_idx <= word_idx + LW'(1);
                tlast_q  <= ((word_idx + LW'(1)) == (len_q - LW'(1)));
              end
            end
          end
          GAP: begin
            gap_cnt <= gap_cnt - GAP_W'(1);
            if (gap_cnt == GAP_W'(1)) begin
              state  <= IDLE;
              busy_q <= 1'b0;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_axis_packet_source.sv
// Scoreboard bench for axis_packet_source: packet-level reference model feeds
// an expected-beat queue; a monitor checks data, tlast, gaps, stalls and counts.
`timescale 1ns/1ps
module tb_axis_packet_source;

  localparam int WORD_BYTES = 4;
  localparam int MAX_WORDS  = 1024;
  localparam int GAP_W      = 32;
  localparam int W          = WORD_BYTES * 8;
  localparam int LW         = $clog2(MAX_WORDS + 1);
  localparam int LIMIT      = 20000;

  typedef struct {
    int          len;
    int          gap;
    int          mode;
    logic [W-1:0] pattern;
  } pkt_cfg_t;

  typedef struct {
    logic [W-1:0] data;
    bit           last;
    int           gap_chk;
  } beat_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             enable = 1'b0;
  logic [LW-1:0]    cfg_len = '0;
  logic [GAP_W-1:0] cfg_gap = '0;
  logic [1:0]       cfg_mode = '0;
  logic [W-1:0]     cfg_pattern = '0;
  logic             m_axis_tready = 1'b0;
  logic [W-1:0]     m_axis_tdata;
  logic             m_axis_tvalid;
  logic             m_axis_tlast;
  logic [31:0]      pkt_count;
  logic             busy;
  logic [W-1:0]     sw_tdata;
  logic             sw_tvalid;
  logic             sw_tlast;
  logic [31:0]      sw_pkt_count;
  logic             sw_busy;

  int        vectors = 0;
  int        miscompares = 0;
  beat_t     q[$];
  pkt_cfg_t  plan[$];
  int        ready_pct = 100;
  int        pkts_started = 0;
  int        exp_pkts = 0;
  bit        trk_valid = 1'b0;
  bit        trk_last = 1'b0;
  bit        trk_ready = 1'b0;
  logic [W-1:0] m_cnt = '0;
  logic [31:0]  m_lfsr = 32'hFFFF_FFFF;

  always #5 clk = ~clk;

  axis_packet_source #(
    .WORD_BYTES(WORD_BYTES), .MAX_WORDS(MAX_WORDS), .GAP_W(GAP_W), .SWAP_ENDIAN(0)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable),
    .cfg_len(cfg_len), .cfg_gap(cfg_gap), .cfg_mode(cfg_mode), .cfg_pattern(cfg_pattern),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
    .pkt_count(pkt_count), .busy(busy)
  );

  axis_packet_source #(
    .WORD_BYTES(WORD_BYTES), .MAX_WORDS(MAX_WORDS), .GAP_W(GAP_W), .SWAP_ENDIAN(1)
  ) dut_sw (
    .clk(clk), .rst(rst), .enable(enable),
    .cfg_len(cfg_len), .cfg_gap(cfg_gap), .cfg_mode(cfg_mode), .cfg_pattern(cfg_pattern),
    .m_axis_tdata(sw_tdata), .m_axis_tvalid(sw_tvalid),
    .m_axis_tready(m_axis_tready), .m_axis_tlast(sw_tlast),
    .pkt_count(sw_pkt_count), .busy(sw_busy)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] bswap(input logic [W-1:0] d);
    logic [W-1:0] r;
    for (int b = 0; b < WORD_BYTES; b++) r[8*b +: 8] = d[8*(WORD_BYTES-1-b) +: 8];
    return r;
  endfunction

  function automatic pkt_cfg_t mk(input int len, input int gap, input int mode, input logic [W-1:0] pat);
    pkt_cfg_t c;
    c.len = len; c.gap = gap; c.mode = mode; c.pattern = pat;
    return c;
  endfunction

  // Reference model: expands one packet's configuration into its expected beats.
  task automatic push_packet(input pkt_cfg_t c, input int gap_chk);
    int    n;
    beat_t b;
    n = (c.len == 0) ? 1 : ((c.len > MAX_WORDS) ? MAX_WORDS : c.len);
    for (int i = 0; i < n; i++) begin
      case (c.mode)
        0: begin b.data = m_cnt; m_cnt = m_cnt + W'(1); end
        1: b.data = W'(i);
        2: begin
          b.data = m_lfsr;
          m_lfsr = {m_lfsr[30:0], m_lfsr[31] ^ m_lfsr[21] ^ m_lfsr[1] ^ m_lfsr[0]};
        end
        default: b.data = c.pattern;
      endcase
      b.last    = (i == n - 1);
      b.gap_chk = (i == 0) ? gap_chk : -1;
      q.push_back(b);
    end
  endtask

  task automatic apply_cfg(input pkt_cfg_t c);
    cfg_len     = LW'(c.len);
    cfg_gap     = GAP_W'(c.gap);
    cfg_mode    = 2'(c.mode);
    cfg_pattern = c.pattern;
  endtask

  // One clock: observe packet starts, then drive tready for the next cycle.
  task automatic step();
    bit hs;
    hs = trk_valid && trk_ready;
    @(posedge clk);
    #2;
    if (m_axis_tvalid && (!trk_valid || (hs && trk_last))) pkts_started++;
    m_axis_tready = ($urandom_range(99) < ready_pct);
    trk_valid = m_axis_tvalid;
    trk_last  = m_axis_tlast;
    trk_ready = m_axis_tready;
  endtask

  // Runs the queued plan; the next packet's config is applied mid-packet to exercise the latch.
  task automatic run_plan(input int pct);
    int base;
    int guard;
    ready_pct = pct;
    base = pkts_started;
    apply_cfg(plan[0]);
    push_packet(plan[0], -1);
    enable = 1'b1;
    for (int k = 0; k < plan.size(); k++) begin
      guard = 0;
      while (pkts_started < base + k + 1 && guard < LIMIT) begin step(); guard++; end
      check("pkt_start", 64'(pkts_started), 64'(base + k + 1));
      if (k + 1 < plan.size()) begin
        apply_cfg(plan[k+1]);
        push_packet(plan[k+1], plan[k].gap);
      end else begin
        enable = 1'b0;
      end
    end
    guard = 0;
    while ((q.size() != 0 || busy) && guard < LIMIT) begin step(); guard++; end
    check("drain_queue", 64'(q.size()), 64'd0);
    check("busy_idle", 64'(busy), 64'd0);
    check("sw_busy_idle", 64'(sw_busy), 64'd0);
    check("pkt_count_end", 64'(pkt_count), 64'(exp_pkts));
    check("sw_pkt_count_end", 64'(sw_pkt_count), 64'(exp_pkts));
    plan.delete();
  endtask

  initial begin : monitor
    beat_t        b;
    bit           prev_stall = 1'b0;
    logic [W-1:0] prev_data = '0;
    bit           prev_last = 1'b0;
    bit           presented = 1'b0;
    int           idle_cnt = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        q.delete();
        exp_pkts   = 0;
        prev_stall = 1'b0;
        presented  = 1'b0;
        idle_cnt   = 0;
        continue;
      end
      if (prev_stall) begin
        check("stall_tvalid", 64'(m_axis_tvalid), 64'd1);
        check("stall_tdata", 64'(m_axis_tdata), 64'(prev_data));
        check("stall_tlast", 64'(m_axis_tlast), 64'(prev_last));
      end
      if (q.size() == 0) check("idle_tvalid", 64'(m_axis_tvalid), 64'd0);
      if (!m_axis_tvalid) begin
        idle_cnt++;
      end else if (q.size() != 0) begin
        b = q[0];
        check("busy_sending", 64'(busy), 64'd1);
        if (!presented && b.gap_chk >= 0) check("gap_cycles", 64'(idle_cnt), 64'(b.gap_chk));
        presented = 1'b1;
        if (m_axis_tready) begin
          check("tdata", 64'(m_axis_tdata), 64'(b.data));
          check("tlast", 64'(m_axis_tlast), 64'(b.last));
          check("sw_tvalid", 64'(sw_tvalid), 64'd1);
          check("sw_tdata", 64'(sw_tdata), 64'(bswap(b.data)));
          check("sw_tlast", 64'(sw_tlast), 64'(b.last));
          if (b.last) begin
            check("pkt_count", 64'(pkt_count), 64'(exp_pkts));
            exp_pkts++;
            idle_cnt = 0;
          end
          void'(q.pop_front());
          presented = 1'b0;
        end
      end
      prev_stall = m_axis_tvalid && !m_axis_tready;
      prev_data  = m_axis_tdata;
      prev_last  = m_axis_tlast;
    end
  end

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: simulation did not finish, %0d vectors, %0d miscompares", vectors, miscompares);
    $fatal(1);
  end

  initial begin : stim
    pkt_cfg_t c;
    int       base;
    int       guard;

    rst = 1'b1;
    repeat (3) step();
    check("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
    check("rst_tlast", 64'(m_axis_tlast), 64'd0);
    check("rst_tdata", 64'(m_axis_tdata), 64'd0);
    check("rst_pkt_count", 64'(pkt_count), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_sw_tdata", 64'(sw_tdata), 64'd0);
    rst = 1'b0;
    step();

    // Back-to-back word-index packets
    plan.push_back(mk(4, 0, 1, '0));
    plan.push_back(mk(4, 0, 1, '0));
    run_plan(100);

    // Running counter under random backpressure
    plan.push_back(mk(8, 0, 0, '0));
    plan.push_back(mk(8, 0, 0, '0));
    run_plan(50);

    // Gap timing and config latched per packet
    plan.push_back(mk(2, 5, 1, '0));
    plan.push_back(mk(3, 5, 1, '0));
    plan.push_back(mk(2, 0, 1, '0));
    run_plan(100);

    // PRBS from the reset seed
    plan.push_back(mk(4, 0, 2, '0));
    run_plan(100);

    // Enable dropped early in a packet, then quiet
    plan.push_back(mk(6, 3, 1, '0));
    run_plan(70);
    repeat (10) step();

    // Length boundaries
    plan.push_back(mk(0, 0, 0, '0));
    plan.push_back(mk(0, 0, 0, '0));
    plan.push_back(mk(0, 2, 0, '0));
    run_plan(100);
    plan.push_back(mk(MAX_WORDS + 5, 0, 1, '0));
    run_plan(100);

    // Constant pattern
    plan.push_back(mk(3, 1, 3, 32'hA5C3_0F96));
    plan.push_back(mk(2, 0, 3, 32'h1234_5678));
    run_plan(60);

    // Randomised episodes
    for (int e = 0; e < 6; e++) begin
      for (int k = 0; k < 3; k++) begin
        c = mk($urandom_range(0, 20), $urandom_range(0, 4), $urandom_range(0, 3), W'($urandom));
        plan.push_back(c);
      end
      run_plan($urandom_range(30, 100));
    end

    // Reset in the middle of a packet
    c = mk(8, 0, 0, '0);
    apply_cfg(c);
    push_packet(c, -1);
    ready_pct = 100;
    base = pkts_started;
    enable = 1'b1;
    guard = 0;
    while (pkts_started < base + 1 && guard < LIMIT) begin step(); guard++; end
    check("pkt_start_pre_rst", 64'(pkts_started), 64'(base + 1));
    repeat (3) step();
    rst = 1'b1;
    enable = 1'b0;
    ready_pct = 0;
    m_axis_tready = 1'b0;
    trk_ready = 1'b0;
    step();
    check("midrst_tvalid", 64'(m_axis_tvalid), 64'd0);
    check("midrst_tlast", 64'(m_axis_tlast), 64'd0);
    check("midrst_tdata", 64'(m_axis_tdata), 64'd0);
    check("midrst_pkt_count", 64'(pkt_count), 64'd0);
    check("midrst_busy", 64'(busy), 64'd0);
    m_cnt  = '0;
    m_lfsr = 32'hFFFF_FFFF;
    step();
    rst = 1'b0;
    step();
    plan.push_back(mk(3, 0, 0, '0));
    run_plan(100);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
